// File: rtl/sr_mem_arbiter.sv
// Round-robin arbiter sharing one memory request/response port among N_REQ requesters.
// One transaction in flight: grant in IDLE, forward in REQ, await response in RESP.
module sr_mem_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GNT_W      = $clog2(N_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_REQ-1:0]                      req_wr_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_wdata_i,
  input  logic [N_REQ-1:0]                      req_valid_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  output logic [N_REQ-1:0]                      resp_valid_o,
  input  logic [N_REQ-1:0]                      resp_ready_i,
  output logic [DATA_WIDTH-1:0]                 resp_rdata_o,
  output logic                                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
  output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
  output logic                                  mem_req_valid_o,
  input  logic                                  mem_req_ready_i,
  input  logic                                  mem_resp_valid_i,
  output logic                                  mem_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
  output logic [GNT_W-1:0]                      grant_o,
  output logic                                  busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state;
  logic [GNT_W-1:0] grant;
  logic [GNT_W-1:0] ptr;
  logic [GNT_W-1:0] arb_idx;
  logic [GNT_W-1:0] cand;
  logic [GNT_W:0]   scan;
  logic             arb_found;

  // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-2 N_REQ works.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr;
    scan      = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan = {1'b0, ptr} + (GNT_W+1)'(i);
      if (scan >= (GNT_W+1)'(N_REQ))
        scan = scan - (GNT_W+1)'(N_REQ);
      cand = scan[GNT_W-1:0];
      if (!arb_found && req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_idx;
            state <= REQ;
          end
        end
        REQ: begin
          if (req_valid_i[grant] && mem_req_ready_i)
            state <= RESP;
        end
        RESP: begin
          if (mem_resp_valid_i && resp_ready_i[grant]) begin
            state <= IDLE;
            if (grant == GNT_W'(N_REQ - 1))
              ptr <= '0;
            else
              ptr <= grant + GNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o      = '0;
    resp_valid_o     = '0;
    mem_wr_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    case (state)
      REQ: begin
        mem_req_valid_o    = req_valid_i[grant];
        mem_wr_o           = req_wr_i[grant];
        mem_addr_o         = req_addr_i[grant];
        mem_wdata_o        = req_wdata_i[grant];
        req_ready_o[grant] = mem_req_ready_i;
      end
      RESP: begin
        resp_valid_o[grant] = mem_resp_valid_i;
        mem_resp_ready_o    = resp_ready_i[grant];
      end
      default: ;
    endcase
  end

  assign resp_rdata_o = mem_rdata_i;
  assign grant_o      = grant;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Self-checking bench for sr_mem_arbiter: directed scenarios plus randomized
// transactions checked against a round-robin reference model.
module tb_sr_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // N_REQ = 2 instance
  logic [1:0]        req_wr, req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0][15:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [31:0]       resp_rdata, mem_wdata, mem_rdata;
  logic [15:0]       mem_addr;
  logic              mem_wr, mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
  logic [0:0]        grant;
  logic              busy;

  sr_mem_arbiter #(.N_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_wr_i(req_wr), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
    .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready),
    .mem_rdata_i(mem_rdata), .grant_o(grant), .busy_o(busy)
  );

  // N_REQ = 3 instance, exercising the non-power-of-2 pointer wrap
  logic [2:0]        req_wr3, req_valid3, req_ready3, resp_valid3, resp_ready3;
  logic [2:0][15:0]  req_addr3;
  logic [2:0][31:0]  req_wdata3;
  logic [31:0]       resp_rdata3, mem_wdata3, mem_rdata3;
  logic [15:0]       mem_addr3;
  logic              mem_wr3, mem_req_valid3, mem_req_ready3, mem_resp_valid3, mem_resp_ready3;
  logic [1:0]        grant3;
  logic              busy3;

  sr_mem_arbiter #(.N_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_wr_i(req_wr3), .req_addr_i(req_addr3), .req_wdata_i(req_wdata3),
    .req_valid_i(req_valid3), .req_ready_o(req_ready3),
    .resp_valid_o(resp_valid3), .resp_ready_i(resp_ready3), .resp_rdata_o(resp_rdata3),
    .mem_wr_o(mem_wr3), .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3),
    .mem_req_valid_o(mem_req_valid3), .mem_req_ready_i(mem_req_ready3),
    .mem_resp_valid_i(mem_resp_valid3), .mem_resp_ready_o(mem_resp_ready3),
    .mem_rdata_i(mem_rdata3), .grant_o(grant3), .busy_o(busy3)
  );

  // Reference: first valid requester at or after pointer p, modulo n.
  function automatic int rr_pick(input int mask, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int c;
      c = (p + i) % n;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req_wr = '0; req_valid = '0; resp_ready = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    req_wr3 = '0; req_valid3 = '0; resp_ready3 = '0; req_addr3 = '0; req_wdata3 = '0;
    mem_req_ready3 = 1'b0; mem_resp_valid3 = 1'b0; mem_rdata3 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_chk++;
    if ({busy, grant, mem_req_valid, mem_resp_ready, req_ready, resp_valid, mem_wr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b grant=%b mrv=%b mrr=%b rr=%b rv=%b wr=%b, required all 0",
               busy, grant, mem_req_valid, mem_resp_ready, req_ready, resp_valid, mem_wr);
    end
    n_chk++;
    if ({mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    req_valid = 2'b01; req_wr = 2'b00; req_addr[0] = 16'h0010;
    mem_req_ready = 1'b1; resp_ready = 2'b01;
    #1;
    n_chk++;
    if (mem_req_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL read_idle: mrv=%b rr=%b, required 0/00", mem_req_valid, req_ready);
    end
    @(negedge clk); #1;
    n_chk++;
    if (mem_req_valid !== 1'b1 || req_ready !== 2'b01 || mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL read_req: mrv=%b rr=%b addr=%h wr=%b, required 1/01/0010/0",
               mem_req_valid, req_ready, mem_addr, mem_wr);
    end
    @(negedge clk);
    req_valid = 2'b00; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    n_chk++;
    if (resp_valid !== 2'b01 || resp_rdata !== 32'hDEADBEEF || mem_resp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_resp: rv=%b rdata=%h mrr=%b, required 01/deadbeef/1",
               resp_valid, resp_rdata, mem_resp_ready);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || grant !== 1'b0) begin
      n_fail++;
      $display("FAIL read_done: busy=%b rv=%b grant=%b, required 0/00/0", busy, resp_valid, grant);
    end
  endtask

  task automatic test_fairness();
    int mp, exp_g;
    apply_reset();
    mp = 0;
    req_valid = 2'b11; mem_req_ready = 1'b1; mem_resp_valid = 1'b1; resp_ready = 2'b11;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk); #1;
      exp_g = rr_pick(3, mp, 2);
      n_chk++;
      if (grant !== 1'(exp_g) || req_ready !== 2'(1 << exp_g) || mem_req_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fair_grant[%0d]: grant=%0d rr=%b mrv=%b, required %0d/%b/1",
                 t, grant, req_ready, mem_req_valid, exp_g, 2'(1 << exp_g));
      end
      mp = (exp_g + 1) % 2;
      @(negedge clk);
      @(negedge clk); #1;
      n_chk++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL fair_idle[%0d]: busy=%b, required 0", t, busy);
      end
    end
    req_valid = 2'b00; mem_resp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int req_hs, resp_hs;
    apply_reset();
    req_hs = 0; resp_hs = 0;
    req_valid = 2'b01; req_wr = 2'b01; req_addr[0] = 16'h1234; req_wdata[0] = 32'h0BADF00D;
    resp_ready = 2'b00;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      mem_req_ready = (c == 4);
      #1;
      if (mem_req_valid && mem_req_ready) req_hs++;
      n_chk++;
      if (busy !== 1'b1 || mem_req_valid !== 1'b1 || mem_addr !== 16'h1234 ||
          mem_wdata !== 32'h0BADF00D || mem_wr !== 1'b1 || req_ready !== {1'b0, mem_req_ready}) begin
        n_fail++;
        $display("FAIL bp_req[%0d]: busy=%b mrv=%b addr=%h wdata=%h wr=%b rr=%b",
                 c, busy, mem_req_valid, mem_addr, mem_wdata, mem_wr, req_ready);
      end
      @(negedge clk);
    end
    req_valid = 2'b00; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h600DCAFE;
    for (int c = 0; c < 4; c++) begin
      resp_ready = (c == 3) ? 2'b01 : 2'b00;
      #1;
      if (mem_resp_valid && mem_resp_ready) resp_hs++;
      n_chk++;
      if (busy !== 1'b1 || resp_valid !== 2'b01 || mem_resp_ready !== resp_ready[0] ||
          mem_req_valid !== 1'b0 || mem_addr !== 16'h0) begin
        n_fail++;
        $display("FAIL bp_resp[%0d]: busy=%b rv=%b mrr=%b mrv=%b addr=%h",
                 c, busy, resp_valid, mem_resp_ready, mem_req_valid, mem_addr);
      end
      @(negedge clk);
    end
    mem_resp_valid = 1'b0; resp_ready = 2'b00;
    #1;
    n_chk++;
    if (busy !== 1'b0 || req_hs != 1 || resp_hs != 1) begin
      n_fail++;
      $display("FAIL bp_count: busy=%b req_hs=%0d resp_hs=%0d, required 0/1/1", busy, req_hs, resp_hs);
    end
  endtask

  task automatic test_write_resp();
    apply_reset();
    req_valid = 2'b10; req_wr = 2'b10; req_addr[1] = 16'h0100; req_wdata[1] = 32'hA5A5A5A5;
    mem_req_ready = 1'b1; resp_ready = 2'b10;
    @(negedge clk); #1;
    n_chk++;
    if (grant !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0100 ||
        mem_wdata !== 32'hA5A5A5A5 || req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL write_req: grant=%b wr=%b addr=%h wdata=%h rr=%b, required 1/1/0100/a5a5a5a5/10",
               grant, mem_wr, mem_addr, mem_wdata, req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00; mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    #1;
    n_chk++;
    if (resp_valid !== 2'b10 || mem_resp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_resp: rv=%b mrr=%b, required 10/1", resp_valid, mem_resp_ready);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_wrap3();
    int mp, exp_g;
    apply_reset();
    mem_req_ready3 = 1'b1; mem_resp_valid3 = 1'b1; resp_ready3 = 3'b111;
    req_valid3 = 3'b010;
    @(negedge clk); #1;
    n_chk++;
    if (grant3 !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_setup: grant=%0d, required 1", grant3);
    end
    @(negedge clk);
    @(negedge clk);
    req_valid3 = 3'b011;
    mp = 2;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); #1;
      exp_g = rr_pick(3, mp, 3);
      n_chk++;
      if (grant3 !== 2'(exp_g) || req_ready3 !== 3'(1 << exp_g)) begin
        n_fail++;
        $display("FAIL wrap_grant[%0d]: grant=%0d rr=%b, required %0d/%b",
                 t, grant3, req_ready3, exp_g, 3'(1 << exp_g));
      end
      mp = (exp_g + 1) % 3;
      @(negedge clk);
      @(negedge clk);
    end
    req_valid3 = '0; mem_resp_valid3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 2'b10; mem_req_ready = 1'b1; resp_ready = 2'b10;
    @(negedge clk);
    @(negedge clk); #1;
    n_chk++;
    if (busy !== 1'b1 || grant !== 1'b1 || mem_resp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_resp_state: busy=%b grant=%b mrr=%b, required 1/1/1", busy, grant, mem_resp_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, grant, mem_req_valid, mem_resp_ready, req_ready, resp_valid} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b grant=%b mrv=%b mrr=%b rr=%b rv=%b, required all 0",
               busy, grant, mem_req_valid, mem_resp_ready, req_ready, resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if (grant !== 1'b1 || mem_req_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_regrant: grant=%b mrv=%b busy=%b, required 1/1/1", grant, mem_req_valid, busy);
    end
    req_valid = 2'b00; mem_req_ready = 1'b0;
  endtask

  task automatic test_random();
    int mp, g, mask, cyc;
    bit hs;
    logic [31:0] rd;
    apply_reset();
    mp = 0;
    for (int t = 0; t < 24; t++) begin
      mask = $urandom_range(3, 1);
      for (int r = 0; r < 2; r++) begin
        req_wr[r] = 1'($urandom); req_addr[r] = 16'($urandom); req_wdata[r] = $urandom;
      end
      req_valid = 2'(mask); mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      resp_ready = 2'($urandom);
      #1;
      n_chk++;
      if (busy !== 1'b0 || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL rnd_idle[%0d]: busy=%b rr=%b, required 0/00", t, busy, req_ready);
      end
      g = rr_pick(mask, mp, 2);
      @(negedge clk);
      hs = 1'b0; cyc = 0;
      while (!hs) begin
        #1;
        n_chk++;
        if (grant !== 1'(g) || mem_req_valid !== 1'b1 || mem_addr !== req_addr[g] ||
            mem_wdata !== req_wdata[g] || mem_wr !== req_wr[g]) begin
          n_fail++;
          $display("FAIL rnd_req[%0d]: grant=%0d mrv=%b addr=%h wdata=%h wr=%b, required %0d/1/%h/%h/%b",
                   t, grant, mem_req_valid, mem_addr, mem_wdata, mem_wr,
                   g, req_addr[g], req_wdata[g], req_wr[g]);
        end
        mem_req_ready = (cyc >= 3) ? 1'b1 : 1'($urandom);
        #1;
        n_chk++;
        if (req_ready !== (mem_req_ready ? 2'(1 << g) : 2'b00)) begin
          n_fail++;
          $display("FAIL rnd_ready[%0d]: rr=%b, required %b", t, req_ready,
                   (mem_req_ready ? 2'(1 << g) : 2'b00));
        end
        hs = mem_req_ready;
        cyc++;
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      req_valid[g] = 1'b0;
      rd = $urandom;
      mem_rdata = rd;
      hs = 1'b0; cyc = 0;
      while (!hs) begin
        mem_resp_valid = (cyc >= 3) ? 1'b1 : 1'($urandom);
        resp_ready[g] = (cyc >= 3) ? 1'b1 : 1'($urandom);
        #1;
        n_chk++;
        if (resp_valid !== (mem_resp_valid ? 2'(1 << g) : 2'b00) ||
            mem_resp_ready !== resp_ready[g] || mem_req_valid !== 1'b0 ||
            (mem_resp_valid && resp_rdata !== rd)) begin
          n_fail++;
          $display("FAIL rnd_resp[%0d]: rv=%b mrr=%b mrv=%b rdata=%h, required %b/%b/0/%h",
                   t, resp_valid, mem_resp_ready, mem_req_valid, resp_rdata,
                   (mem_resp_valid ? 2'(1 << g) : 2'b00), resp_ready[g], rd);
        end
        hs = mem_resp_valid && resp_ready[g];
        cyc++;
        @(negedge clk);
      end
      mp = (g + 1) % 2;
      mem_resp_valid = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_backpressure();
    test_write_resp();
    test_wrap3();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_mem_arbiter.md
# sr_mem_arbiter

Round-robin arbiter that shares one simple memory request/response port, the port the sr_cpu core drives, between N_REQ requesters (cores, DMA, PMU readout). It sits between the requesters and a single sr_axi_adapter, so several masters reach the NoC through one AXI node. Exactly one transaction is in flight at a time: the arbiter grants, forwards the request, waits for its response, then re-arbitrates.

## Interface
Parameters:
- N_REQ, 2, number of requesters (≥2)
- ADDR_WIDTH, 16, memory address width
- DATA_WIDTH, 32, read/write data width
- GNT_W, $clog2(N_REQ), grant index width (derived, not overridden)

Ports (clock and reset first; per-requester buses are packed arrays indexed by requester):
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_wr_i  in  N_REQ  write (1) / read (0)
- req_addr_i  in  N_REQ×ADDR_WIDTH  request address
- req_wdata_i  in  N_REQ×DATA_WIDTH  write data
- req_valid_i  in  N_REQ  request valid
- req_ready_o  out  N_REQ  request accepted
- resp_valid_o  out  N_REQ  response valid
- resp_ready_i  in  N_REQ  response accepted
- resp_rdata_o  out  DATA_WIDTH  read data, broadcast to all requesters, qualified only by resp_valid_o
- mem_wr_o  out  1  to adapter mem_wr_i
- mem_addr_o  out  ADDR_WIDTH  to adapter mem_addr_i
- mem_wdata_o  out  DATA_WIDTH  to adapter mem_wdata_i
- mem_req_valid_o  out  1  to adapter
- mem_req_ready_i  in  1  from adapter
- mem_resp_valid_i  in  1  from adapter
- mem_resp_ready_o  out  1  to adapter
- mem_rdata_i  in  DATA_WIDTH  from adapter
- grant_o  out  GNT_W  current/last granted requester
- busy_o  out  1  state ≠ IDLE

## Operation
- The downstream returns exactly one response per accepted request, reads and writes alike, in order.
- Registers: state {IDLE, REQ, RESP}, grant (GNT_W), prio pointer ptr (GNT_W).
- IDLE: if any req_valid_i is set, grant ← first set index searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1. State → REQ. No outputs are asserted to requesters in IDLE.
- REQ: mem_req_valid_o = req_valid_i[grant]. mem_wr/addr/wdata are muxed from the grant. req_ready_o[grant] = mem_req_ready_i; all other ready bits are 0. On mem_req_valid_o & mem_req_ready_i the state → RESP.
- RESP: resp_valid_o[grant] = mem_resp_valid_i and mem_resp_ready_o = resp_ready_i[grant]; other resp_valid bits are 0. On handshake, state → IDLE and ptr ← (grant+1) mod N_REQ. The wrap uses an explicit compare, not a power-of-2 overflow.
- In IDLE and RESP, mem_req_valid_o = 0 and mem_wr_o/mem_addr_o/mem_wdata_o = 0.
- Requesters hold valid and payload stable until ready. If a requester drops valid in REQ, the arbiter stays in REQ with mem_req_valid_o low. There is no timeout and no re-arbitration.
- Non-granted requesters stall without loss.

## Timing
- Reset (async assert, sync release by system): state = IDLE, grant = 0, ptr = 0, busy_o = 0. All valid/ready outputs are 0 and mem_* payload is 0.
- Arbitration costs 1 cycle. A request seen in IDLE at edge k has mem_req_valid_o high in cycle k+1.
- Request path in REQ is combinational (req_valid → mem_req_valid, mem_req_ready → req_ready). The response path in RESP is likewise combinational.
- Minimum turnaround is 3 cycles per transaction (IDLE, REQ, RESP) with zero-wait downstream. Back-to-back throughput is 1 transaction per 3 cycles.
- A response handshake and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle with the updated ptr.
- Reset mid-transaction: immediate return to IDLE. The downstream adapter shares rst_n, and the in-flight transaction is abandoned.
- grant_o holds its value through IDLE until the next arbitration.

## Test plan
- Single read: req 0 reads addr 0x0010, adapter ready immediately and returns rdata 0xDEADBEEF one cycle later. Expect mem_req_valid_o one cycle after valid, req_ready_o = 01, resp_valid_o = 01 with rdata 0xDEADBEEF, and busy_o back to 0 after the handshake.
- Contention fairness: N_REQ = 2, both requesters continuously valid for 6 transactions. Expect grant sequence 0,1,0,1,0,1 and no req_ready to the non-granted requester.
- Backpressure: mem_req_ready_i held low 4 cycles, then mem_resp_ready stalled by resp_ready_i = 0 for 3 cycles. Expect the payload stable throughout, state held, and exactly one request and one response handshake.
- Write response: req 1 writes 0xA5A5A5A5 to 0x0100. Expect mem_wr_o = 1 and mem_wdata_o = 0xA5A5A5A5, and the write response routed only to resp_valid_o[1].
- Wrap-around: N_REQ = 3, ptr = 2, only req 0 and req 1 valid. Expect grant 0, then 1, then 0.
- Reset mid-operation: assert rst_n low while in RESP. Expect all outputs 0 asynchronously and grant_o = 0. After release, a pending req 1 is granted on the next cycle's arbitration.
